cordic_vectoring_pipeline: RTL and testbench



---
 rtl/cordic_pkg.sv | 50 +++++
 rtl/cordic_vec_stage.sv | 43 ++++
 rtl/cordic_vectoring_pipeline.sv | 91 +++++++++
 tb/tb_cordic_vectoring_pipeline.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, the arctangent table and the pipeline stage record.
// Used by both the rotation and the vectoring pipelines.
package cordic_pkg;

   localparam int PI_Q14      = 51472;
   localparam int HALF_PI_Q14 = 25736;
   localparam int K_Q15       = 19898;

   // The stage record is sized for the standard 16-bit sample, 18-bit angle build.
   localparam int REC_WIDTH = 16;
   localparam int REC_XY_W  = REC_WIDTH + 2;
   localparam int REC_Z_W   = 18;

   typedef struct packed {
      logic                       valid;
      logic signed [REC_XY_W-1:0] x;
      logic signed [REC_XY_W-1:0] y;
      logic signed [REC_Z_W-1:0]  z;
   } stage_t;

   // round(atan(2^-i) * 2^14)
   function automatic int atan_q14(input int i);
      case (i)
         0:       return 12868;
         1:       return 7596;
         2:       return 4014;
         3:       return 2037;
         4:       return 1023;
         5:       return 512;
         6:       return 256;
         7:       return 128;
         8:       return 64;
         9:       return 32;
         10:      return 16;
         11:      return 8;
         12:      return 4;
         13:      return 2;
         14:      return 1;
         default: return 0;
      endcase
   endfunction

   // Multiplies a non-negative magnitude by 1/gain (Q15) with round-to-nearest.
   function automatic logic [REC_WIDTH:0] gain_comp(input logic [REC_WIDTH:0] mag);
      logic [31:0] prod;
      prod = 32'(mag) * 32'(K_Q15) + 32'(1 << 14);
      return (REC_WIDTH + 1)'(prod >> 15);
   endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation: drives y toward zero and
// accumulates the applied rotation into z.
module cordic_vec_stage
   import cordic_pkg::*;
#(
   parameter int SHIFT    = 0,
   parameter int ATAN_VAL = 0
) (
   input  logic   clk,
   input  logic   reset,
   input  stage_t prev,
   output stage_t next
);

   logic signed [REC_XY_W-1:0] x_prev, y_prev, x_sh, y_sh;
   logic signed [REC_Z_W-1:0]  z_prev, atan_step;

   assign x_prev    = prev.x;
   assign y_prev    = prev.y;
   assign z_prev    = prev.z;
   assign x_sh      = x_prev >>> SHIFT;
   assign y_sh      = y_prev >>> SHIFT;
   assign atan_step = REC_Z_W'(ATAN_VAL);

   // NOTE: non-blocking assignments so each stage samples its predecessor's pre-edge value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         next <= '0;
      end else begin
         next.valid <= prev.valid;
         if (!y_prev[REC_XY_W-1]) begin
            next.x <= x_prev + y_sh;
            next.y <= y_prev - x_sh;
            next.z <= z_prev + atan_step;
         end else begin
            next.x <= x_prev - y_sh;
            next.y <= y_prev + x_sh;
            next.z <= z_prev - atan_step;
         end
      end
   end

endmodule

// File: rtl/cordic_vectoring_pipeline.sv
// Fully pipelined vectoring CORDIC: (x, y) -> magnitude and atan2(y, x) in radians * 2^14.
// Define CORDIC_GAIN_COMP_EN to add a registered 1/gain stage so mag_out is the true magnitude.
module cordic_vectoring_pipeline
   import cordic_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int ITER    = 16,
   parameter int ANGLE_W = 18
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   x_in,
   input  logic [WIDTH-1:0]   y_in,
   output logic               out_valid,
   output logic [WIDTH:0]     mag_out,
   output logic [ANGLE_W-1:0] angle_out
);

   localparam int XW = WIDTH + 2;

   if ((XW != REC_XY_W) || (ANGLE_W != REC_Z_W) || (ITER < 1) || (ITER > WIDTH)) begin : g_bad_cfg
      $error("cordic_vectoring_pipeline: unsupported WIDTH/ANGLE_W/ITER combination");
   end

   stage_t pipe [0:ITER];

   logic signed [XW-1:0] x_ext, y_ext;
   assign x_ext = XW'(signed'(x_in));
   assign y_ext = XW'(signed'(y_in));

   // Stage 0 folds the left half-plane into x >= 0 so the iterations converge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pipe[0] <= '0;
      end else begin
         pipe[0].valid <= in_valid;
         if (!x_ext[XW-1]) begin
            pipe[0].x <= x_ext;
            pipe[0].y <= y_ext;
            pipe[0].z <= '0;
         end else if (!y_ext[XW-1]) begin
            pipe[0].x <= y_ext;
            pipe[0].y <= -x_ext;
            pipe[0].z <= REC_Z_W'(HALF_PI_Q14);
         end else begin
            pipe[0].x <= -y_ext;
            pipe[0].y <= x_ext;
            pipe[0].z <= -REC_Z_W'(HALF_PI_Q14);
         end
      end
   end

   for (genvar i = 0; i < ITER; i++) begin : g_stage
      cordic_vec_stage #(
         .SHIFT    (i),
         .ATAN_VAL (atan_q14(i))
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .prev  (pipe[i]),
         .next  (pipe[i+1])
      );
   end

   // x never decreases along the pipe, so a zero final x means a zero input vector,
   // whose accumulated z is meaningless and is reported as angle 0.
   logic                     zero_vec;
   logic [ANGLE_W-1:0]       angle_fin;
   assign zero_vec  = (pipe[ITER].x == '0);
   assign angle_fin = zero_vec ? '0 : pipe[ITER].z;

`ifdef CORDIC_GAIN_COMP_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         mag_out   <= '0;
         angle_out <= '0;
      end else begin
         out_valid <= pipe[ITER].valid;
         mag_out   <= gain_comp(pipe[ITER].x[WIDTH:0]);
         angle_out <= angle_fin;
      end
   end
`else
   assign out_valid = pipe[ITER].valid;
   assign mag_out   = pipe[ITER].x[WIDTH:0];
   assign angle_out = angle_fin;
`endif

endmodule

// File: tb/tb_cordic_vectoring_pipeline.sv
// Scoreboard bench for the vectoring CORDIC: directed vectors with hand-computed results,
// a back-to-back burst and a mid-stream reset.
module tb_cordic_vectoring_pipeline;

   localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int  LAT  = ITER + 2;
   localparam bit  COMP = 1'b1;
`else
   localparam int  LAT  = ITER + 1;
   localparam bit  COMP = 1'b0;
`endif

   typedef struct {
      int     mag;
      int     ang;
      int     ang_tol;
      longint due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [15:0] x_in, y_in;
   logic        out_valid;
   logic [16:0] mag_out;
   logic [17:0] angle_out;

   exp_t   sb[$];
   longint cyc      = 0;
   int     n_checks = 0;
   int     n_fail   = 0;
   bit     zero_chk = 1'b1;

   cordic_vectoring_pipeline #(
      .WIDTH   (16),
      .ITER    (ITER),
      .ANGLE_W (18)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .mag_out   (mag_out),
      .angle_out (angle_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req, input int tol);
      int diff;
      n_checks++;
      diff = act - req;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, req, tol, cyc);
      end
   endtask

   // Pushes the expected result, then presents the sample for one clock.
   task automatic issue(input int x, input int y, input int mag_gain, input int mag_true,
                        input int ang, input int atol);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      x_in     = 16'(x);
      y_in     = 16'(y);
      e.mag     = COMP ? mag_true : mag_gain;
      e.ang     = ang;
      e.ang_tol = atol;
      e.due     = cyc + LAT;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x_in     = '0;
      y_in     = '0;
   endtask

   task automatic drain();
      int budget = 200;
      while (sb.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      check("drain_timeout", sb.size(), 0, 0);
      repeat (2) @(posedge clk);
   endtask

   // Monitor: compares every out_valid pulse with the head of the scoreboard.
   always @(negedge clk) begin
      int   ang_act;
      exp_t e;
      ang_act = $signed(angle_out);
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("spurious_out_valid", int'(out_valid), 0, 0);
         end else begin
            e = sb.pop_front();
            check("latency", int'(cyc), int'(e.due), 0);
            check("mag", int'(mag_out), e.mag, e.mag / 1000 + 2);
            check("angle", ang_act, e.ang, e.ang_tol);
         end
      end else begin
         if (sb.size() > 0 && sb[0].due < cyc) begin
            check("missing_out_valid", 0, 1, 0);
            void'(sb.pop_front());
         end
         if (zero_chk) begin
            check("idle_mag", int'(mag_out), 0, 0);
            check("idle_angle", ang_act, 0, 0);
         end
      end
   end

   int burst_x   [5] = '{20000, 14142, 14142,      0,      0};
   int burst_y   [5] = '{    0, 14142, -14142, 20000, -20000};
   int burst_ang [5] = '{    0, 12868, -12868, 25736, -25736};

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      x_in     = '0;
      y_in     = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1 zero_chk = 1'b0;

      // Directed single samples.
      issue( 16384,      0, 26981, 16384,      0, 8); idle();
      issue( 16384,  16384, 38156, 23170,  12868, 8); idle();
      issue( 16384, -16384, 38156, 23170, -12868, 8); idle();
      issue(     0,  16384, 26981, 16384,  25736, 8); idle();
      issue(     0, -16384, 26981, 16384, -25736, 8); idle();
      issue(-16384,      0, 26981, 16384,  51472, 8); idle();
      issue(-32768, -32768, 76311, 46341, -38604, 8); idle();
      issue(     0,      0,     0,     0,      0, 2); idle();
      drain();

      // Back-to-back burst of 20 samples on a radius-20000 circle.
      for (int i = 0; i < 20; i++)
         issue(burst_x[i % 5], burst_y[i % 5], 32935, 20000, burst_ang[i % 5], 8);
      idle();
      drain();

      // Reset while 8 samples are in flight; none of them may emerge.
      for (int i = 0; i < 8; i++)
         issue(burst_x[i % 5], burst_y[i % 5], 32935, 20000, burst_ang[i % 5], 8);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x_in     = '0;
      y_in     = '0;
      reset    = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      reset    = 1'b1;
      zero_chk = 1'b1;
      repeat (LAT + 3) @(posedge clk);
      #1 zero_chk = 1'b0;

      issue(-16384,      0, 26981, 16384,  51472, 8);
      issue( 16384,  16384, 38156, 23170,  12868, 8);
      issue(     0, -16384, 26981, 16384, -25736, 8);
      idle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
